key_debouncer: RTL and testbench

- Upstream conditioning stage for the push-button inputs feeding the lab counter, which counts presses and latches switches.
- Per key: 2-FF synchroniser, then a stability counter, then a debounced level.
- Produces single-cycle press and release strobes in the clk100_i domain, so the downstream counter sees exactly one event per physical press.
- Board keys are active-low; all outputs are active-high.

---
 rtl/key_debouncer_pkg.sv | 38 +++
 rtl/key_debounce_ch.sv | 144 ++++++++++++++
 rtl/key_debouncer.sv | 51 +++++
 tb/tb_key_debouncer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// key_debouncer_pkg
//   Shared constants and types for the push-button conditioning block.
//   - KEY_PRESSED / KEY_RELEASED : raw board levels (keys are active-low)
//   - ch_state_t, STABLE/CHANGING : per-channel debounce state encoding
//   - key_evt_t                  : per-channel output bundle (level + strobes)
//   - DEF_* timing defaults      : 100 MHz board values
//   - max_int()                  : elaboration helper for counter sizing
// -----------------------------------------------------------------------------
package key_debouncer_pkg;

   // Raw electrical level of a board key.
   localparam logic KEY_PRESSED  = 1'b0;
   localparam logic KEY_RELEASED = 1'b1;

   // Two-state channel FSM, kept as plain constants for legacy tools.
   typedef logic [0:0] ch_state_t;
   localparam ch_state_t STABLE   = 1'b0;
   localparam ch_state_t CHANGING = 1'b1;

   // Channel result, all fields active-high.
   typedef struct packed {
      logic level;   // debounced state, 1 = pressed
      logic press;   // one-cycle strobe on accepted press / auto-repeat
      logic rel;     // one-cycle strobe on accepted release
   } key_evt_t;

   // Defaults: 10 ms debounce, 500 ms first repeat, 100 ms repeat period.
   localparam int DEF_NUM_KEYS        = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_REPEAT_DELAY    = 50000000;
   localparam int DEF_REPEAT_PERIOD   = 10000000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//   One key channel: 2-FF synchroniser, stability counter, debounced level and
//   registered press/release strobes. With KEY_AUTOREPEAT_EN defined, a held
//   key also produces repeat press strobes (REPEAT_DELAY after the accepted
//   press, then every REPEAT_PERIOD). Without it, no repeat logic exists.
//
//   Ports
//     clk100_i : system clock
//     rstn_i   : asynchronous active-low reset
//     key_i    : raw asynchronous key, 0 = pressed
//     evt_o    : {level, press, rel}, all registered, active-high
// -----------------------------------------------------------------------------
module key_debounce_ch
   import key_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic     clk100_i,
   input  logic     rstn_i,
   input  logic     key_i,
   output key_evt_t evt_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // A bad configuration leaves this named block in the elaborated hierarchy,
   // which is easy to spot; the timing parameters are otherwise only read by
   // the optional repeat logic.
   localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (REPEAT_DELAY >= 1) &&
                           (REPEAT_PERIOD >= 1);
   if (!CFG_OK) begin : g_bad_cfg
   end

   // ---------------------------------------------------------------------
   // Synchroniser; flops reset to "released" so a key held through reset
   // looks like a fresh press once reset lifts.
   // ---------------------------------------------------------------------
   logic s1, s2;

   always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1 <= KEY_RELEASED;
         s2 <= KEY_RELEASED;
      end else begin
         s1 <= key_i;
         s2 <= s1;
      end
   end

   // ---------------------------------------------------------------------
   // Stability counter. The counter only runs while s2 disagrees with the
   // accepted level; the DEBOUNCE_CYCLES-th consecutive disagreeing sample
   // is accepted, so a run of DEBOUNCE_CYCLES-1 samples is rejected.
   // ---------------------------------------------------------------------
   ch_state_t        state;
   logic             acc_lvl;   // accepted raw level
   logic [CNT_W-1:0] cnt;
   logic             differs, done, accept_press, accept_rel;

   assign differs      = (s2 != acc_lvl);
   assign done         = differs && (state == CHANGING) && (cnt == DB_LAST);
   assign accept_press = done && (s2 == KEY_PRESSED);
   assign accept_rel   = done && (s2 == KEY_RELEASED);

   always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state   <= STABLE;
         acc_lvl <= KEY_RELEASED;
         cnt     <= '0;
      end else if (!differs) begin
         state <= STABLE;
         cnt   <= '0;
      end else if (done) begin
         state   <= STABLE;
         acc_lvl <= s2;
         cnt     <= '0;
      end else begin
         state <= CHANGING;
         cnt   <= cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Auto-repeat
   // ---------------------------------------------------------------------
   logic level_q, press_q, rel_q;
   logic rpt_fire;

`ifdef KEY_AUTOREPEAT_EN
   localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_periodic;   // first repeat already issued

   // A release accepted on this edge suppresses any repeat due on it.
   assign rpt_fire = level_q && !accept_rel &&
                     (rpt_cnt == (rpt_periodic ? RPT_NEXT : RPT_FIRST));

   always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rpt_cnt      <= '0;
         rpt_periodic <= 1'b0;
      end else if (!level_q || accept_press || accept_rel) begin
         rpt_cnt      <= '0;
         rpt_periodic <= 1'b0;
      end else if (rpt_fire) begin
         rpt_cnt      <= '0;
         rpt_periodic <= 1'b1;
      end else begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Registered outputs; level moves on the accept edge together with the
   // strobe, and the two strobes cannot coincide.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         if (done) level_q <= (s2 == KEY_PRESSED);
         press_q <= accept_press | rpt_fire;
         rel_q   <= accept_rel;
      end
   end

   assign evt_o.level = level_q;
   assign evt_o.press = press_q;
   assign evt_o.rel   = rel_q;

endmodule

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Conditions NUM_KEYS active-low board push-buttons into debounced
//   active-high levels plus single-cycle press/release strobes in the
//   clk100_i domain. Channels are independent instances of key_debounce_ch.
//   Optional auto-repeat: define KEY_AUTOREPEAT_EN.
//
//   Ports
//     clk100_i      : system clock
//     rstn_i        : asynchronous active-low reset
//     key_i         : raw keys, 0 = pressed
//     key_level_o   : debounced state, 1 = pressed
//     key_press_o   : one-cycle strobe per accepted press (and repeat)
//     key_release_o : one-cycle strobe per accepted release
// -----------------------------------------------------------------------------
module key_debouncer
   import key_debouncer_pkg::*;
#(
   parameter int NUM_KEYS        = DEF_NUM_KEYS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                clk100_i,
   input  logic                rstn_i,
   input  logic [NUM_KEYS-1:0] key_i,
   output logic [NUM_KEYS-1:0] key_level_o,
   output logic [NUM_KEYS-1:0] key_press_o,
   output logic [NUM_KEYS-1:0] key_release_o
);

   key_evt_t [NUM_KEYS-1:0] evt;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk100_i (clk100_i),
         .rstn_i   (rstn_i),
         .key_i    (key_i[k]),
         .evt_o    (evt[k])
      );

      assign key_level_o[k]   = evt[k].level;
      assign key_press_o[k]   = evt[k].press;
      assign key_release_o[k] = evt[k].rel;
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4 (REPEAT 8/4).
// Expected strobes are queued with their due cycle when stimulus is driven;
// a negedge monitor pops and compares them, and checks every other cycle
// for silence and the expected level.
module tb_key_debouncer;

   localparam int NK = 2;
   localparam int DC = 4;
   localparam int RD = 8;
   localparam int RP = 4;
   localparam int LAT = 2 + DC;   // drive-to-visible edges

   logic          clk100_i = 1'b0;
   logic          rstn_i;
   logic [NK-1:0] key_i;
   logic [NK-1:0] key_level_o, key_press_o, key_release_o;

   always #5 clk100_i = ~clk100_i;

   key_debouncer #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DC),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk100_i      (clk100_i),
      .rstn_i        (rstn_i),
      .key_i         (key_i),
      .key_level_o   (key_level_o),
      .key_press_o   (key_press_o),
      .key_release_o (key_release_o)
   );

   typedef struct {
      int         cyc;
      logic [1:0] press;
      logic [1:0] rel;
      logic [1:0] lvl;
   } exp_t;

   exp_t       q[$];
   int         tests = 0;
   int         fails = 0;
   int         ecnt  = 0;      // posedges seen so far
   logic [1:0] lvl_model = 2'b00;

   always @(posedge clk100_i) ecnt <= ecnt + 1;

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s at edge %0d: got {lvl,press,rel}=%b expected %b", tag, ecnt, obs, exp_v);
      end
   endtask

   // Monitor: one comparison per cycle.
   always @(negedge clk100_i) begin
      exp_t       e;
      logic [1:0] ep, er;
      ep = 2'b00;
      er = 2'b00;
      if (!rstn_i) begin
         lvl_model = 2'b00;
         check("in_reset", {key_level_o, key_press_o, key_release_o}, 6'b0);
      end else begin
         while (q.size() > 0 && q[0].cyc < ecnt) begin
            e = q.pop_front();
            tests++;
            assert (e.cyc >= ecnt) else begin
               fails++;
               $error("FAIL stale_event: due edge %0d still pending at edge %0d", e.cyc, ecnt);
            end
         end
         if (q.size() > 0 && q[0].cyc == ecnt) begin
            e = q.pop_front();
            ep = e.press;
            er = e.rel;
            lvl_model = e.lvl;
         end
         check("monitor", {key_level_o, key_press_o, key_release_o}, {lvl_model, ep, er});
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk100_i);
   endtask

   task automatic drive(input logic [1:0] v);
      @(negedge clk100_i);
      key_i = v;
   endtask

   task automatic expect_at(input int cyc, input logic [1:0] p, input logic [1:0] r,
                            input logic [1:0] l);
      q.push_back('{cyc, p, r, l});
   endtask

   initial begin
      int k;
      int guard;

      // 1. reset with keys released
      rstn_i = 1'b0;
      key_i  = 2'b11;
      #1;
      check("reset_async", {key_level_o, key_press_o, key_release_o}, 6'b0);
      wait_n(3);
      #2 rstn_i = 1'b1;
      wait_n(20);
      check("reset_idle", {key_level_o, key_press_o, key_release_o}, 6'b0);

      // 2. clean press then release on key 0
      drive(2'b10); expect_at(ecnt + LAT, 2'b01, 2'b00, 2'b01);
      wait_n(10);
      drive(2'b11); expect_at(ecnt + LAT, 2'b00, 2'b01, 2'b00);
      wait_n(10);

      // 3. glitch rejection: 3-sample low pulse, then 3-sample high dip
      drive(2'b10); wait_n(2); drive(2'b11);
      wait_n(10);
      check("glitch_low", {key_level_o, key_press_o, key_release_o}, 6'b000000);
      drive(2'b10); expect_at(ecnt + LAT, 2'b01, 2'b00, 2'b01);
      wait_n(10);
      drive(2'b11); wait_n(2); drive(2'b10);
      wait_n(10);
      check("glitch_high", {key_level_o, key_press_o, key_release_o}, 6'b010000);
      drive(2'b11); expect_at(ecnt + LAT, 2'b00, 2'b01, 2'b00);
      wait_n(10);

      // 4. bounce: toggle every 2 cycles for 12 cycles, then settle low
      for (int i = 0; i < 3; i++) begin
         drive(2'b10); wait_n(1);
         drive(2'b11); wait_n(1);
      end
      drive(2'b10); expect_at(ecnt + LAT, 2'b01, 2'b00, 2'b01);
      wait_n(10);
      drive(2'b11); expect_at(ecnt + LAT, 2'b00, 2'b01, 2'b00);
      wait_n(10);

      // 5a. both keys on the same edge
      drive(2'b00); expect_at(ecnt + LAT, 2'b11, 2'b00, 2'b11);
      wait_n(10);
      drive(2'b11); expect_at(ecnt + LAT, 2'b00, 2'b11, 2'b00);
      wait_n(10);

      // 5b. key 0 accepted, key 1 pressed, reset hits key 1 at count 2
      drive(2'b10); expect_at(ecnt + LAT, 2'b01, 2'b00, 2'b01);
      wait_n(10);
      drive(2'b00);
      wait_n(4);
      #2 rstn_i = 1'b0;
      #1;
      check("reset_midcount", {key_level_o, key_press_o, key_release_o}, 6'b0);
      wait_n(2);
      #2 rstn_i = 1'b1;
      // both keys still held: fresh press for each at the normal latency
      k = ecnt;
      expect_at(k + LAT, 2'b11, 2'b00, 2'b11);
      wait_n(10);
      drive(2'b11); expect_at(ecnt + LAT, 2'b00, 2'b11, 2'b00);
      wait_n(10);

      // 6. long hold on key 0 (repeats only with auto-repeat)
      drive(2'b10);
      k = ecnt;
      expect_at(k + LAT, 2'b01, 2'b00, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
      for (int t = k + LAT + RD; t < k + 30 + LAT; t += RP)
         expect_at(t, 2'b01, 2'b00, 2'b01);
`endif
      wait_n(29);
      drive(2'b11); expect_at(ecnt + LAT, 2'b00, 2'b01, 2'b00);
      wait_n(12);

      // drain
      guard = 0;
      while (q.size() > 0 && guard < 200) begin
         wait_n(1);
         guard++;
      end
      tests++;
      assert (q.size() == 0) else begin
         fails++;
         $error("FAIL drain: %0d expected events never seen, expected 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
